// File: rtl/onehot_pulse_pkg.sv
// rtl/onehot_pulse_pkg.sv - shared types and helpers for the one-hot pulse decoder
package onehot_pulse_pkg;

   // Sequencer phases: waiting for work, driving a line, forced quiet time.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } pulse_state_e;

   // Flat state codes so the state register stays a plain logic vector.
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_PULSE = PULSE;
   localparam logic [1:0] ST_GAP   = GAP;

   // Request as seen by producers of the default 16-line, 4-bit-length build.
   typedef struct packed {
      logic [3:0] id;
      logic [3:0] len;
   } pulse_req_t;

   // Gap counter width: $clog2(gap+1), never narrower than one bit so a
   // zero-gap build still has a legal (unused) counter.
   function automatic int unsigned gap_cnt_width(input int unsigned gap);
      return (gap == 0) ? 1 : $clog2(gap + 1);
   endfunction

endpackage

// File: rtl/onehot_pulse_buf.sv
// rtl/onehot_pulse_buf.sv - one-entry request holding register with valid flag
module onehot_pulse_buf
   import onehot_pulse_pkg::*;
#(
   parameter int unsigned IdW  = 4,
   parameter int unsigned LenW = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic [IdW-1:0]  id_i,
   input  logic [LenW-1:0] len_i,
   input  logic            consume_i,
   output logic            valid_o,
   output logic [IdW-1:0]  id_o,
   output logic [LenW-1:0] len_o
);

   logic            valid_q;
   logic [IdW-1:0]  id_q;
   logic [LenW-1:0] len_q;

   // Capture a request when empty; drop the flag when the sequencer takes it.
   // Load only happens while empty, so it never coincides with consume.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         len_q   <= '0;
      end else begin
         if (load_i) begin
            valid_q <= 1'b1;
            id_q    <= id_i;
            len_q   <= len_i;
         end else if (consume_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid_o = valid_q;
   assign id_o    = id_q;
   assign len_o   = len_q;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - ID stream to timed one-hot strobe decoder
module onehot_pulse_decoder
   import onehot_pulse_pkg::*;
#(
   parameter int unsigned Width     = 16,
   parameter int unsigned IDWidth   = $clog2(Width),
   parameter int unsigned LenWidth  = 4,
   parameter int unsigned GapCycles = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [IDWidth-1:0]  id_i,
   input  logic [LenWidth-1:0] len_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [Width-1:0]    onehot_o,
   output logic                active_o,
   output logic                err_o
);

   localparam int unsigned        GapCntW = gap_cnt_width(GapCycles);
   localparam logic [IDWidth:0]   WidthC  = (IDWidth + 1)'(Width);
   localparam logic [GapCntW-1:0] GapInit = GapCntW'(GapCycles);
   localparam bit                 HasGap  = (GapCycles != 0);

   logic [1:0]          state_q, state_d;
   logic [IDWidth-1:0]  act_id_q;
   logic [LenWidth-1:0] cnt_q;
   logic [GapCntW-1:0]  gap_cnt_q;

   logic                buf_valid;
   logic [IDWidth-1:0]  buf_id;
   logic [LenWidth-1:0] buf_len;

   logic                accept;
   logic                in_range;
   logic                req_ok;
   logic                cnt_last;
   logic                load_act;
   logic                load_src_buf;
   logic                direct_load;
   logic                buf_load;
   logic                buf_consume;
   logic                gap_load;
   logic [IDWidth-1:0]  src_id;
   logic [LenWidth-1:0] src_len;
   logic [IDWidth-1:0]  next_id;
   logic [Width-1:0]    onehot_d;

   // A zero length still produces a single-cycle strobe.
   function automatic logic [LenWidth-1:0] len_eff(input logic [LenWidth-1:0] l);
      return (l == '0) ? LenWidth'(1) : l;
   endfunction

   // Handshake and range qualification of the incoming request.
   assign ready_o  = !buf_valid;
   assign accept   = valid_i && ready_o;
   assign in_range = ({1'b0, id_i} < WidthC);
   assign req_ok   = accept && in_range;
   assign cnt_last = (cnt_q == LenWidth'(1));

   // Active registers come from the buffer when draining it, otherwise
   // straight from the input (idle start, or zero-gap back-to-back hand-off).
   assign src_id      = load_src_buf ? buf_id  : id_i;
   assign src_len     = load_src_buf ? buf_len : len_i;
   assign direct_load = load_act && !load_src_buf;
   assign buf_load    = req_ok && !direct_load;

   onehot_pulse_buf #(
      .IdW  (IDWidth),
      .LenW (LenWidth)
   ) u_buf (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (buf_load),
      .id_i      (id_i),
      .len_i     (len_i),
      .consume_i (buf_consume),
      .valid_o   (buf_valid),
      .id_o      (buf_id),
      .len_o     (buf_len)
   );

   // Next-state and load decisions for the pulse sequencer.
   always_comb begin
      state_d      = state_q;
      load_act     = 1'b0;
      load_src_buf = 1'b0;
      buf_consume  = 1'b0;
      gap_load     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_ok) begin
               load_act = 1'b1;
               state_d  = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (cnt_last) begin
               // A request arriving on the final edge counts as pending
               // work, exactly like one already sitting in the buffer.
               if (buf_valid || req_ok) begin
                  if (HasGap) begin
                     gap_load = 1'b1;
                     state_d  = ST_GAP;
                  end else begin
                     load_act     = 1'b1;
                     load_src_buf = buf_valid;
                     buf_consume  = buf_valid;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GapCntW'(1)) begin
               load_act     = 1'b1;
               load_src_buf = 1'b1;
               buf_consume  = 1'b1;
               state_d      = ST_PULSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register plus active line index and pulse-length down-counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         act_id_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load_act) begin
            act_id_q <= src_id;
            cnt_q    <= len_eff(src_len);
         end else if (state_q == ST_PULSE && cnt_q != '0) begin
            cnt_q <= cnt_q - LenWidth'(1);
         end
      end
   end

   // Counts the forced all-zero cycles between two consecutive pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gap_cnt_q <= '0;
      end else begin
         if (gap_load) begin
            gap_cnt_q <= GapInit;
         end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GapCntW'(1);
         end
      end
   end

   // Decode from the upcoming state so the outputs are registered yet
   // line up with the cycle the state is in.
   assign next_id  = load_act ? src_id : act_id_q;
   assign onehot_d = (state_d == ST_PULSE) ? (Width'(1) << next_id) : '0;

   // Registered outputs; err marks an out-of-range request for one cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         onehot_o <= '0;
         active_o <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         onehot_o <= onehot_d;
         active_o <= |onehot_d;
         err_o    <= accept && !in_range;
      end
   end

endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
- Inverse of the priority encoder: accepts a stream of binary IDs over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles.
- Used to fire per-channel strobes (enables, clears, selects) from a compact ID bus.
- Sits downstream of ID-producing logic. Has a one-entry input buffer so the producer is not stalled while a pulse is in flight.

Parameters:
- Width, 16, number of one-hot output lines.
- IDWidth, $clog2(Width), ID bus width (derived, not overridden).
- LenWidth, 4, width of the pulse-length field.
- GapCycles, 1, forced all-zero cycles between consecutive pulses (0 = back-to-back).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- id_i  input  IDWidth  requested line index.
- len_i  input  LenWidth  pulse length in cycles; 0 is treated as 1.
- valid_i  input  1  request valid.
- ready_o  output  1  request can be accepted.
- onehot_o  output  Width  decoded, registered one-hot output.
- active_o  output  1  onehot_o is non-zero this cycle.
- err_o  output  1  one-cycle flag for an out-of-range ID.

Behaviour:
- Reset (async, rst_ni low): FSM to IDLE, buffer empty, counters 0, onehot_o=0, active_o=0, err_o=0, ready_o=1.
- Handshake:
  - A request is accepted on a rising edge where valid_i && ready_o.
  - ready_o = !buf_valid.
  - valid_i may be held high with id_i/len_i unchanged until accepted.
- FSM states:
  - IDLE: an accepted request loads the active registers directly, bypassing the buffer, and goes to PULSE.
  - PULSE: onehot_o = 1 << id; cnt counts down from max(len,1). At cnt==1:
    - If buf_valid and GapCycles>0: go to GAP.
    - If buf_valid and GapCycles==0: load from the buffer and stay in PULSE.
    - Otherwise go to IDLE.
  - GAP: onehot_o=0 for exactly GapCycles cycles, then load from the buffer and go to PULSE.
- Buffer:
  - A request accepted while not IDLE goes into the buffer.
  - The buffer is freed on the edge where it loads into the active registers.
  - ready_o rises in the following cycle. No combinational ready-from-consume path.
- Latency: request accepted at edge k in IDLE → onehot_o valid during cycles k+1 … k+len.
- Out-of-range (id_i >= Width, only possible when Width is not a power of 2):
  - The request is accepted and consumed.
  - err_o is high in cycle k+1 only.
  - No pulse, no state change, never enters the buffer.
- active_o = |onehot_o, registered alongside it.
- Reset mid-PULSE or mid-GAP: outputs go to 0 immediately (async); the buffered request is discarded.
- Counter width: LenWidth bits, no wrap. The maximum pulse is 2^LenWidth−1 cycles.

Decomposition:
- Package onehot_pulse_pkg holds:
  - the state enum typedef (IDLE, PULSE, GAP);
  - a request struct {id, len};
  - the localparam for gap-counter width, $clog2(GapCycles+1).
- Sub-module onehot_pulse_buf: one-entry request register with valid flag, load/consume controls and async reset.
- The top-level block contains the FSM, counters, range check and decode.

Test Plan (Width=16, LenWidth=4, GapCycles=1 unless stated):
- Reset check: rst_ni low, valid_i=1 → onehot_o=0, active_o=0, err_o=0, ready_o=1. Release rst_ni → idle with no pulse.
- Single pulse: accept id=5, len=3 at edge k → onehot_o=16'h0020 in cycles k+1..k+3, then 16'h0000; ready_o stays 1.
- Buffered back-to-back: id=0 len=2, then id=15 len=1 held valid → ready_o drops for the second request. Sequence is 16'h0001, 16'h0001, 16'h0000 (gap), 16'h8000, then 0. Repeat with GapCycles=0 → no zero cycle in between.
- len=0: accept id=7, len=0 → onehot_o=16'h0080 for exactly one cycle.
- Out-of-range (Width=12, IDWidth=4): accept id=13 → err_o high one cycle, onehot_o stays 0. A following id=2 len=1 pulses 12'h004 normally.
- Reset mid-operation: assert rst_ni in the 2nd cycle of an id=3 len=8 pulse with a request buffered → onehot_o=0 at once. After release the buffered request never appears and ready_o=1.
